// File: rtl/m_sertx_if.sv
// ---------------------------------------------------------------------------
// m_sertx_if : CPU-side bus for the serial transmitter.
//
//   din    byte to transmit
//   ld     one-cycle load strobe for din
//   div    bit period minus one, in clk cycles
//   pen    parity enable
//   podd   1 = odd parity, 0 = even parity
//   stop2  1 = two stop bits, 0 = one stop bit
//   txd    serial line out (idles high)
//   txrdy  holding register empty, ld will be accepted
//   txidle shifter idle and holding register empty
//
// master : the bus decode driving the transmitter
// slave  : the transmitter itself
// ---------------------------------------------------------------------------
interface m_sertx_if #(
    parameter int DIVW = 12
);
    logic [7:0]      din;
    logic            ld;
    logic [DIVW-1:0] div;
    logic            pen;
    logic            podd;
    logic            stop2;
    logic            txd;
    logic            txrdy;
    logic            txidle;

    modport master (
        output din, ld, div, pen, podd, stop2,
        input  txd, txrdy, txidle
    );

    modport slave (
        input  din, ld, div, pen, podd, stop2,
        output txd, txrdy, txidle
    );
endinterface

// File: rtl/m_sertx.sv
// ---------------------------------------------------------------------------
// m_sertx : asynchronous serial transmitter.
//
// Bytes written through a single-entry holding register are shifted out
// LSB-first on txd as: start bit, 8 data bits, optional parity bit, then
// one or two stop bits. Each bit lasts div+1 clk cycles. Frame settings
// (div, pen, podd, stop2) are captured when a byte moves from the holding
// register into the shifter and stay fixed for that frame.
//
// Ports:
//   clk  system clock, all state changes on its rising edge
//   r    synchronous active-high reset, wins over ld
//   bus  m_sertx_if slave modport (din/ld/div/pen/podd/stop2 in,
//        txd/txrdy/txidle out, all outputs straight from flops)
// ---------------------------------------------------------------------------
module m_sertx #(
    parameter int DIVW = 12
) (
    input  logic      clk,
    input  logic      r,
    m_sertx_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t          state_reg,    state_next;
    logic [7:0]      hold_reg,     hold_next;
    logic            hold_full_reg, hold_full_next;
    logic [7:0]      shift_reg,    shift_next;
    logic            par_reg,      par_next;
    logic            pen_reg,      pen_next;
    logic            stop2_reg,    stop2_next;
    logic [DIVW-1:0] div_lat_reg,  div_lat_next;
    logic [DIVW-1:0] div_cnt_reg,  div_cnt_next;
    logic [2:0]      bit_cnt_reg,  bit_cnt_next;
    logic            txd_reg,      txd_next;
    logic            txidle_reg,   txidle_next;

    logic            tick;
    logic            load_frame;
    logic [8:0]      par_chain;

    // Parity of the byte about to enter the shifter, seeded with podd so
    // the chain end is directly the bit to put on the line.
    assign par_chain[0] = bus.podd;
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_par
            assign par_chain[gi+1] = par_chain[gi] ^ hold_reg[gi];
        end
    endgenerate

    assign tick = (div_cnt_reg == div_lat_reg);

    always_comb begin
        state_next     = state_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        shift_next     = shift_reg;
        par_next       = par_reg;
        pen_next       = pen_reg;
        stop2_next     = stop2_reg;
        div_lat_next   = div_lat_reg;
        div_cnt_next   = tick ? '0 : div_cnt_reg + {{(DIVW-1){1'b0}}, 1'b1};
        bit_cnt_next   = bit_cnt_reg;
        txd_next       = txd_reg;
        load_frame     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                div_cnt_next = '0;
                txd_next     = 1'b1;
                if (hold_full_reg) begin
                    load_frame = 1'b1;
                end
            end
            S_START: begin
                if (tick) begin
                    state_next   = S_DATA;
                    bit_cnt_next = 3'd0;
                    txd_next     = shift_reg[0];
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_cnt_reg == 3'd7) begin
                        bit_cnt_next = 3'd0;
                        if (pen_reg) begin
                            state_next = S_PAR;
                            txd_next   = par_reg;
                        end else begin
                            state_next = S_STOP;
                            txd_next   = 1'b1;
                        end
                    end else begin
                        shift_next   = {1'b0, shift_reg[7:1]};
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        txd_next     = shift_reg[1];
                    end
                end
            end
            S_PAR: begin
                if (tick) begin
                    state_next   = S_STOP;
                    bit_cnt_next = 3'd0;
                    txd_next     = 1'b1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    // bit_cnt_reg counts completed stop bits here
                    if (stop2_reg && (bit_cnt_reg == 3'd0)) begin
                        bit_cnt_next = 3'd1;
                    end else if (hold_full_reg) begin
                        load_frame = 1'b1;   // back-to-back, no idle gap
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                txd_next   = 1'b1;
            end
        endcase

        // Holding register -> shifter transfer. A full holding register
        // means txrdy is low, so ld can never coincide with the transfer.
        if (load_frame) begin
            state_next     = S_START;
            shift_next     = hold_reg;
            par_next       = par_chain[8];
            pen_next       = bus.pen;
            stop2_next     = bus.stop2;
            div_lat_next   = bus.div;
            div_cnt_next   = '0;
            bit_cnt_next   = 3'd0;
            txd_next       = 1'b0;
            hold_full_next = 1'b0;
        end else if (bus.ld && !hold_full_reg) begin
            hold_next      = bus.din;
            hold_full_next = 1'b1;
        end

        txidle_next = (state_next == S_IDLE) && !hold_full_next;
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state_reg     <= S_IDLE;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            shift_reg     <= '0;
            par_reg       <= 1'b0;
            pen_reg       <= 1'b0;
            stop2_reg     <= 1'b0;
            div_lat_reg   <= '0;
            div_cnt_reg   <= '0;
            bit_cnt_reg   <= 3'd0;
            txd_reg       <= 1'b1;
            txidle_reg    <= 1'b1;
        end else begin
            state_reg     <= state_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            shift_reg     <= shift_next;
            par_reg       <= par_next;
            pen_reg       <= pen_next;
            stop2_reg     <= stop2_next;
            div_lat_reg   <= div_lat_next;
            div_cnt_reg   <= div_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            txd_reg       <= txd_next;
            txidle_reg    <= txidle_next;
        end
    end

    assign bus.txd    = txd_reg;
    assign bus.txrdy  = ~hold_full_reg;
    assign bus.txidle = txidle_reg;

endmodule

// File: doc/m_sertx.md
Name: m_sertx

Overview:
- Asynchronous serial transmitter for the comms port. It is the transmit end of the serial link whose receive side is already in the design.
- Accepts bytes from the CPU bus decode through a single-entry holding register and shifts them out LSB-first on TXD.
- Frame: start bit, 8 data bits, optional parity bit, then 1 or 2 stop bits. Bit rate comes from a programmable clock divisor.
- Built in the same synchronous style as the rest of the netlist: one clock, every flop reset through the data path.

Parameters:
- DIVW, 12, width of the bit-period divisor input.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- R  input  1  synchronous, active-high reset.
- DIN  input  8  byte to transmit.
- LD  input  1  load strobe; one-cycle write of DIN into the holding register.
- DIV  input  DIVW  bit period minus one, in CLK cycles.
- PEN  input  1  parity enable.
- PODD  input  1  1 = odd parity, 0 = even parity.
- STOP2  input  1  1 = two stop bits, 0 = one stop bit.
- TXD  output  1  serial line out; idles high.
- TXRDY  output  1  holding register empty (LD will be accepted).
- TXIDLE  output  1  shifter idle and holding register empty.

Behaviour:
Reset
- R sampled high at an edge gives, from the next cycle: TXD=1, TXRDY=1, TXIDLE=1, holding register empty, state IDLE, divider=0.
- A reset mid-frame aborts the frame immediately: TXD=1 next cycle, and the byte in the holding register is discarded.
- R has priority over LD.

Holding register
- LD high at an edge while TXRDY=1 captures DIN; TXRDY=0 from the next cycle.
- LD while TXRDY=0 is ignored: no overwrite, no error flag.

State machine
- States: IDLE, START, DATA, PAR, STOP.
- IDLE → START: at any edge where the holding register is full. At that edge:
  - the shifter loads the holding register, which empties (TXRDY=1 next cycle);
  - PEN, PODD, STOP2 and DIV are latched for the whole frame;
  - the divider clears;
  - TXD=0 from the next cycle.
- Latency: LD accepted at edge n, transfer at edge n+1, TXD low during the cycle after edge n+1.

Bit timing
- Every bit lasts exactly DIV+1 cycles. DIV=0 gives one bit per clock.
- The divider counts 0..DIV_latched. A bit tick occurs when it equals DIV_latched, and it wraps to 0.
- Changing the DIV input mid-frame has no effect until the next frame.

Transitions on bit tick
- START → DATA.
- DATA: 8 bits, LSB first, TXD = shifter[0]; shift right on each tick. After bit 7, go to PAR if PEN, otherwise STOP.
- PAR: TXD = XOR(data[7:0]) ^ PODD. Then STOP.
- STOP: TXD=1 for 1 or 2 bit periods.
  - At the final stop-bit tick, if the holding register is full, go directly to START with the same load actions. Back-to-back frames have no idle gap.
  - Otherwise go to IDLE.

Outputs
- TXIDLE=1 only when state=IDLE and the holding register is empty.
- All outputs are registered; no combinational path from inputs to outputs.

Frame length
- (10 + PEN + STOP2) × (DIV+1) cycles.

Test Plan:
- Reset, then LD with DIN=0x55, DIV=3, PEN=0, STOP2=0 → TXD low 2 edges after LD. Sequence 0,1,0,1,0,1,0,1,0 then stop 1, each held 4 cycles. TXRDY=1 one cycle after the transfer. TXIDLE=1 exactly 40 cycles after TXD falls.
- DIN=0x07, PEN=1, PODD=0, DIV=0 → parity bit 1. Repeat with PODD=1 → parity bit 0. STOP2=1 → two high bit periods; frame is 12 cycles.
- LD 0xA1, then LD 0x3C as soon as TXRDY=1, DIV=1 → second start bit immediately follows the first stop bit with no extra high cycle. Total 40 cycles.
- LD 0x11 then LD 0x22 while TXRDY=0 → only 0x11 is sent. TXRDY stays 0 until transfer.
- Assert R mid-DATA of frame 0xF0 with a byte waiting in the holding register → next cycle TXD=1, TXRDY=1, TXIDLE=1. Nothing more is transmitted.
- Change DIV from 3 to 0 mid-frame → current frame keeps 4-cycle bits. The next frame uses 1-cycle bits.
